// File: rtl/aes_pkg.sv
// Constants and state encoding shared by the byte-serial AES datapath blocks
// (pts_block and stp_key).
package aes_pkg;

  localparam int unsigned NBYTES  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned BLOCK_W = NBYTES * BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOF  = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/pts_block.sv
// Parallel-to-serial block streamer: captures a 128-bit block and emits it
// MSB byte first behind a one-cycle start-of-frame strobe.
module pts_block
  import aes_pkg::*;
#(
  parameter int unsigned NBYTES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic                     hold,
  output logic [BYTE_W-1:0]        z,
  output logic                     sof,
  output logic                     valid,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned DW = BYTE_W * NBYTES;
  localparam int unsigned CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_t            state, state_n;
  logic [DW-1:0]     sreg, sreg_n;
  logic [CW-1:0]     count, count_n;
  logic [BYTE_W-1:0] z_n;
  logic              sof_n, valid_n, busy_n, done_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      count <= '0;
      z     <= '0;
      sof   <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      count <= count_n;
      z     <= z_n;
      sof   <= sof_n;
      valid <= valid_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Outputs are next-state decoded so every output leaves a flop.
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    count_n = count;
    z_n     = '0;
    sof_n   = 1'b0;
    valid_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SOF;
          sreg_n  = a;
          count_n = '0;
          sof_n   = 1'b1;
          busy_n  = 1'b1;
        end
      end
      SOF: begin
        state_n = SEND;
        z_n     = sreg[DW-1 -: BYTE_W];
        valid_n = 1'b1;
        busy_n  = 1'b1;
      end
      SEND: begin
        if (hold) begin
          z_n    = z;
          busy_n = 1'b1;
        end else begin
          sreg_n  = {sreg[DW-BYTE_W-1:0], {BYTE_W{1'b0}}};
          count_n = count + 1'b1;
          if (count == LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            z_n     = sreg[DW-BYTE_W-1 -: BYTE_W];
            valid_n = 1'b1;
            busy_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pts_block.sv
// Randomized self-checking bench for pts_block: each frame's expected output
// trace is generated from the block value and a per-byte hold schedule.
module tb_pts_block;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         hold;
  logic [127:0] a;
  logic [7:0]   z;
  logic         sof, valid, busy, done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic [7:0] z;
    logic       sof;
    logic       valid;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t trace[$];

  localparam logic [127:0] BASIC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] INCR  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] REV   = 128'hffeeddccbbaa99887766554433221100;

  always #5 clk = ~clk;

  pts_block #(.NBYTES(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .hold (hold),
    .z    (z),
    .sof  (sof),
    .valid(valid),
    .busy (busy),
    .done (done)
  );

  function automatic obs_t observe();
    obs_t o;
    o.z = z; o.sof = sof; o.valid = valid; o.busy = busy; o.done = done;
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected cycle-by-cycle trace: sof, each byte once valid then repeated
  // (invalid) once per hold, then the done pulse.
  task automatic build(input logic [127:0] blk, input int unsigned holds[16]);
    obs_t e;
    trace.delete();
    e = '0; e.sof = 1'b1; e.busy = 1'b1;
    trace.push_back(e);
    for (int k = 0; k < 16; k++) begin
      e = '0; e.z = blk[127-8*k -: 8]; e.valid = 1'b1; e.busy = 1'b1;
      trace.push_back(e);
      e.valid = 1'b0;
      for (int unsigned r = 0; r < holds[k]; r++) trace.push_back(e);
    end
    e = '0; e.done = 1'b1;
    trace.push_back(e);
  endtask

  // Entered mid-cycle with the DUT in IDLE; returns mid-cycle. With chain
  // set, it returns inside the done cycle so the next call starts there.
  task automatic run_frame(input logic [127:0] blk, input int unsigned holds[16],
                           input int busy_start, input bit chain, input string name);
    build(blk, holds);
    start = 1'b1;
    a     = blk;
    hold  = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    for (int i = 0; i < trace.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), 32'(observe()), 32'(trace[i]));
      if (i == trace.size() - 1) begin
        if (chain) return;
        start = 1'b0;
        a     = rnd128();
        hold  = 1'($urandom_range(0, 1));
      end else begin
        if (trace[i].sof)
          hold = 1'($urandom_range(0, 1));
        else
          hold = trace[i+1].busy && !trace[i+1].valid && !trace[i+1].sof;
        start = (i == busy_start) || ($urandom_range(0, 9) == 0);
        a     = (i == busy_start) ? '1 : rnd128();
      end
      @(posedge clk); #1;
    end
    check({name, "_idle"}, 32'(observe()), 32'(0));
  endtask

  int unsigned h[16];
  int unsigned hz[16];

  initial begin
    hz = '{default: 0};
    rst = 1'b0; start = 1'b0; hold = 1'b0; a = '0;
    #12;
    check("reset", 32'(observe()), 32'(0));
    start = 1'b1; a = BASIC;
    @(posedge clk); #1;
    check("reset_start", 32'(observe()), 32'(0));
    rst = 1'b1; start = 1'b0; hold = 1'b1; a = rnd128();
    @(posedge clk); #1;
    check("idle", 32'(observe()), 32'(0));

    run_frame(BASIC, hz, -1, 1'b0, "basic");

    h = hz; h[4] = 3;
    run_frame(BASIC, h, -1, 1'b0, "hold44");

    run_frame(BASIC, hz, 6, 1'b0, "busy_start");

    run_frame(BASIC, hz, -1, 1'b1, "b2b_a");
    run_frame(REV, hz, -1, 1'b0, "b2b_b");

    run_frame(INCR, hz, -1, 1'b0, "incr");

    // Abort while byte 88 is on the bus.
    start = 1'b1; a = BASIC; hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_abort", 32'(observe()), 32'({8'h88, 4'b0110}));
    #2 rst = 1'b0;
    #1 check("abort_async", 32'(observe()), 32'(0));
    @(posedge clk); #1;
    check("abort_held", 32'(observe()), 32'(0));
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("abort_nodone", 32'(observe()), 32'(0));
    run_frame(BASIC, hz, -1, 1'b0, "post_abort");

    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < 16; k++)
        h[k] = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      run_frame(rnd128(), h, -1, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", f));
    end
    run_frame(rnd128(), hz, -1, 1'b0, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pts_block.md
# pts_block

Parallel-to-serial block streamer: captures a 128-bit word (ciphertext or round key) in one cycle and emits it as 16 bytes, most significant byte first, on an 8-bit bus. It is the transmit-side counterpart of the `stp_key` serial-to-parallel loader. Its `sof` strobe and byte stream are timed so they can drive `stp_key`'s `start` and `a` inputs directly. It sits at the output of the low-area AES core, between the state register and the byte-wide external port.

## Interface
- `NBYTES`, default 16: bytes per block. It is fixed at 16 for AES and exists only for readability. The data width is 8·`NBYTES`.
- `clk`, input, 1: the single clock. All logic is rising-edge.
- `rst`, input, 1: asynchronous, active-low reset. Assertion forces the reset state immediately. Release is synchronous to `clk`.
- `start`, input, 1: load request. It is sampled only in IDLE.
- `a`, input, 128: parallel block. It is captured on the edge that accepts `start`.
- `hold`, input, 1: downstream stall. It is honoured only in SEND.
- `z`, output, 8: current byte.
- `sof`, output, 1: start-of-frame strobe, high for one cycle before the first byte.
- `valid`, output, 1: `z` carries a live byte this cycle.
- `busy`, output, 1: a frame is in progress, from SOF through the last byte.
- `done`, output, 1: one-cycle pulse after the last byte.

## Operation
- **Reset values:** state=IDLE, shift register=0, count=0, `z`=0, `sof`=0, `valid`=0, `busy`=0, `done`=0.
- **FSM states:** IDLE, SOF, SEND.
- **IDLE:**
  - If `start`=1: load `sreg`←`a`, clear count, and go to SOF.
  - Otherwise remain in IDLE.
  - `a` is ignored whenever `start` is not accepted.
- **SOF:** lasts exactly one cycle. `sof`=1, `busy`=1, `valid`=0, `z`=0. Always proceeds to SEND.
- **SEND:**
  - `z`=`sreg[127:120]`, `valid`=1, `busy`=1.
  - On each edge with `hold`=0: shift `sreg` left by 8 with zero fill, and increment the 4-bit count.
  - After the 16th byte (count wraps 15→0), go to IDLE and assert `done` for one cycle.
- **Hold:**
  - With `hold`=1 in SEND, `sreg`, count and `z` freeze, and `valid`=0 for that cycle.
  - `hold` is ignored in IDLE and SOF.
  - Holding on the 16th byte delays the exit to IDLE.
- **Start while busy:** `start` in SOF or SEND is ignored, with no queuing. The frame in flight is not disturbed.
- **Back-to-back frames:** `start` in the `done` cycle is accepted, because the FSM is already in IDLE. The next `sof` follows immediately.
- **Reset mid-frame:** the frame is aborted, all outputs return to their reset values at once, and no `done` is produced.
- **Output registration:** all outputs are registered, with no combinational path from inputs to outputs.

## Timing
- **Frame latency:**
  - `start` is accepted at edge E0.
  - `sof`=1 during E0→E1.
  - Byte k (k=0..15) is on `z` during E(k+1)→E(k+2) when there is no hold.
  - `done`=1 during E17→E18.
- **Frame length and throughput:** a frame is 17 cycles from `sof` to the last byte. The minimum start-to-start period is 18 cycles.
- **Loopback contract:** `stp_key` samples `start` at E1 and byte k at E(k+2), so the two blocks connect wire-to-wire when `hold`=0.
- **`busy` timing:** `busy` rises in the cycle after the accepting edge and falls together with the last `valid`.

## Structure
- **Shared package `aes_pkg`:** holds `NBYTES`=16, `BLOCK_W`=128, `BYTE_W`=8, and the state encodings IDLE=2'd0, SOF=2'd1, SEND=2'd2. `stp_key` and this block both use the package.
- **No sub-modules:** a single module containing the FSM, the 128-bit shift register and the 4-bit counter.
- **State 2'd3:** unreachable. It decodes to IDLE on the next edge.
- **Target size:** about 150 lines of RTL.

## Test plan
- **Basic frame:** `rst` pulse low, then `start`=1 with `a`=00112233445566778899aabbccddeeff.
  - `sof` for 1 cycle, then `z`=00,11,22,…,ff on 16 consecutive `valid` cycles.
  - `done` pulse at E17, then all outputs 0.
- **Loopback:** `z`→`stp_key.a`, `sof`→`stp_key.start`, same `a`.
  - `stp_key.ready`=1 with its `z`=00112233445566778899aabbccddeeff.
  - Repeat with `a`=000102030405060708090a0b0c0d0e0f.
- **Hold:** `hold`=1 for 3 cycles while byte 44 is on `z`.
  - `z` stays 44 with `valid`=0 for those 3 cycles, then 55…ff resumes.
  - `done` is delayed by exactly 3 cycles.
- **Start while busy:** `start`=1 with `a`=all-ff at byte 5 of a frame.
  - The stream continues 55…ff unchanged, and no second `sof` follows.
- **Back-to-back:** `start` in the `done` cycle with `a`=ffeeddccbbaa99887766554433221100.
  - The next cycle gives `sof`=1, then ff,ee,…,00.
- **Reset mid-frame:** `rst`=0 asynchronously while byte 88 is on `z`.
  - `z`=0 and `valid`/`busy`/`sof`/`done`=0 immediately, with no `done`.
  - After release, a new `start` produces a clean full frame.
